// File: rtl/bram_read_arbiter_pkg.sv
// Shared definitions for the image BRAM read arbiter: FSM encoding, port ids
// and the default image geometry.
package bram_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int IMG_ADDR_W = 13;
    localparam int IMG_DATA_W = 8;

    function automatic arb_state_e own_state(input logic port_id);
        return (port_id == PORT1) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/bram_read_arbiter_if.sv
// Requester-side bundle of the BRAM read arbiter: two request/ack/grant/rvalid
// channels plus the broadcast read data.
interface bram_read_arbiter_if #(
    parameter int ADDR_W = bram_read_arbiter_pkg::IMG_ADDR_W,
    parameter int DATA_W = bram_read_arbiter_pkg::IMG_DATA_W
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              ack0;
    logic              gnt0;
    logic              rvalid0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req0, addr0, req1, addr1,
        input  ack0, gnt0, rvalid0, ack1, gnt1, rvalid1, rdata
    );

    modport slave (
        input  req0, addr0, req1, addr1,
        output ack0, gnt0, rvalid0, ack1, gnt1, rvalid1, rdata
    );
endinterface

// File: rtl/bram_read_arbiter_tag_pipe.sv
// Read-tag shift register: follows each issued read for RD_LAT cycles so the
// returning BRAM word is flagged valid for the port that asked for it.
module bram_rd_tag_pipe
    import bram_read_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk_100mhz,
    input  logic reset_n,
    input  logic issue,
    input  logic issue_id,
    output logic rvalid0,
    output logic rvalid1,
    output logic any_valid
);

    logic [RD_LAT-1:0] valid_q, valid_d;
    logic [RD_LAT-1:0] id_q, id_d;

    always_comb begin
        valid_d    = '0;
        id_d       = '0;
        valid_d[0] = issue;
        id_d[0]    = issue_id;
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            id_d[i]    = id_q[i-1];
        end
    end

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign rvalid0   = valid_q[RD_LAT-1] && (id_q[RD_LAT-1] == PORT0);
    assign rvalid1   = valid_q[RD_LAT-1] && (id_q[RD_LAT-1] == PORT1);
    assign any_valid = |valid_q;

endmodule

// File: rtl/bram_read_arbiter.sv
// Two-port round-robin read arbiter for the image BRAM with burst locking;
// port 0 is the pixel streamer, port 1 the debug readback engine.
//
// state   | meaning
// IDLE    | no owner, BRAM idle
// OWN0    | port 0 owns the BRAM, each req0 cycle issues a read
// OWN1    | port 1 owns the BRAM, each req1 cycle issues a read
module bram_read_arbiter
    import bram_read_arbiter_pkg::*;
#(
    parameter int ADDR_W    = IMG_ADDR_W,
    parameter int DATA_W    = IMG_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk_100mhz,
    input  logic              reset_n,
    bram_read_arbiter_if.slave bus,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_data,
    output logic              busy
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_e    state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          last_srv_q, last_srv_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;

    logic own_id;
    logic own_req;
    logic oth_req;
    logic issue;
    logic release_own;
    logic tag_busy;

    always_comb begin
        own_id  = (state_q == ST_OWN1) ? PORT1 : PORT0;
        own_req = 1'b0;
        oth_req = 1'b0;
        case (state_q)
            ST_OWN0: begin
                own_req = bus.req0;
                oth_req = bus.req1;
            end
            ST_OWN1: begin
                own_req = bus.req1;
                oth_req = bus.req0;
            end
            default: ;
        endcase
        issue       = own_req;
        release_own = (state_q != ST_IDLE) &&
                      (!own_req || (issue && (burst_q == BURST_LAST) && oth_req));
    end

    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        last_srv_d = last_srv_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 && bus.req1)
                    state_d = (last_srv_q == PORT1) ? ST_OWN0 : ST_OWN1;
                else if (bus.req0)
                    state_d = ST_OWN0;
                else if (bus.req1)
                    state_d = ST_OWN1;
            end
            default: begin
                if (release_own) begin
                    last_srv_d = own_id;
                    burst_d    = '0;
                    state_d    = oth_req ? own_state(~own_id) : ST_IDLE;
                end else if (issue) begin
                    // Lone requester keeps the BRAM; the counter just wraps
                    burst_d = (burst_q == BURST_LAST) ? '0 : burst_q + 1'b1;
                end
            end
        endcase
        gnt0_d = (state_d == ST_OWN0);
        gnt1_d = (state_d == ST_OWN1);
    end

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            burst_q    <= '0;
            last_srv_q <= PORT1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            last_srv_q <= last_srv_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
        end
    end

    assign bram_en   = issue;
    assign bram_addr = !issue ? '0 : ((own_id == PORT1) ? bus.addr1 : bus.addr0);

    assign bus.ack0  = issue && (state_q == ST_OWN0);
    assign bus.ack1  = issue && (state_q == ST_OWN1);
    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.rdata = bram_data;

    bram_rd_tag_pipe #(
        .RD_LAT(RD_LAT)
    ) u_tag_pipe (
        .clk_100mhz(clk_100mhz),
        .reset_n   (reset_n),
        .issue     (issue),
        .issue_id  (own_id),
        .rvalid0   (bus.rvalid0),
        .rvalid1   (bus.rvalid1),
        .any_valid (tag_busy)
    );

    assign busy = (state_q != ST_IDLE) || tag_busy;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench for bram_read_arbiter: one RD_LAT=1 and one RD_LAT=2 instance
// against a BRAM model holding mem[a] = a[7:0] ^ 8'h5A.
module tb_bram_read_arbiter;
    import bram_read_arbiter_pkg::*;

    localparam int AW = 13;
    localparam int DW = 8;

    logic clk_100mhz = 1'b0;
    logic reset_n    = 1'b0;
    logic sel2       = 1'b0;
    int   n_tests    = 0;
    int   n_fail     = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    bram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
    bram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b2 ();

    logic          bram_en1, bram_en2, busy1, busy2;
    logic [AW-1:0] bram_addr1, bram_addr2;
    logic [DW-1:0] bram_data1 = '0;
    logic [DW-1:0] bram_data2 = '0;
    logic [DW-1:0] d2_stage   = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    bram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_BURST(16)) dut1 (
        .clk_100mhz(clk_100mhz), .reset_n(reset_n), .bus(b1),
        .bram_en(bram_en1), .bram_addr(bram_addr1), .bram_data(bram_data1), .busy(busy1)
    );

    bram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .MAX_BURST(16)) dut2 (
        .clk_100mhz(clk_100mhz), .reset_n(reset_n), .bus(b2),
        .bram_en(bram_en2), .bram_addr(bram_addr2), .bram_data(bram_data2), .busy(busy2)
    );

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            logic [31:0] iv;
            iv = i;
            mem[i] = iv[7:0] ^ 8'h5A;
        end
    end

    always @(posedge clk_100mhz) begin
        if (bram_en1) bram_data1 <= mem[bram_addr1];
        if (bram_en2) d2_stage <= mem[bram_addr2];
        bram_data2 <= d2_stage;
    end

    wire          m_gnt0  = sel2 ? b2.gnt0    : b1.gnt0;
    wire          m_gnt1  = sel2 ? b2.gnt1    : b1.gnt1;
    wire          m_ack0  = sel2 ? b2.ack0    : b1.ack0;
    wire          m_ack1  = sel2 ? b2.ack1    : b1.ack1;
    wire          m_rv0   = sel2 ? b2.rvalid0 : b1.rvalid0;
    wire          m_rv1   = sel2 ? b2.rvalid1 : b1.rvalid1;
    wire [DW-1:0] m_rdata = sel2 ? b2.rdata   : b1.rdata;
    wire          m_busy  = sel2 ? busy2      : busy1;
    wire          m_en    = sel2 ? bram_en2   : bram_en1;
    wire [AW-1:0] m_addr  = sel2 ? bram_addr2 : bram_addr1;

    logic [7:0] exp_data [5] = '{8'h5A, 8'h5B, 8'h58, 8'h59, 8'h5E};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic r0, input logic [AW-1:0] a0,
                         input logic r1, input logic [AW-1:0] a1);
        if (sel2) begin
            b2.req0 = r0; b2.addr0 = a0; b2.req1 = r1; b2.addr1 = a1;
        end else begin
            b1.req0 = r0; b1.addr0 = a0; b1.req1 = r1; b1.addr1 = a1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        b1.req0 = 0; b1.addr0 = '0; b1.req1 = 0; b1.addr1 = '0;
        b2.req0 = 0; b2.addr0 = '0; b2.req1 = 0; b2.addr1 = '0;
        repeat (2) @(posedge clk_100mhz);
        #1;
        reset_n = 1'b1;
    endtask

    // Port 0 streams addresses 0..4, advancing on ack0
    task automatic run_stream(input int lat);
        int addr;
        sel2 = (lat == 2);
        do_reset();
        addr = 0;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) tick();
            drive(addr < 5, AW'(addr), 1'b0, '0);
            settle();
            check($sformatf("s%0d_gnt0_c%0d", lat, c), m_gnt0, c >= 1 && c <= 6);
            check($sformatf("s%0d_ack0_c%0d", lat, c), m_ack0, c >= 1 && c <= 5);
            check($sformatf("s%0d_en_c%0d", lat, c), m_en, c >= 1 && c <= 5);
            check($sformatf("s%0d_rv0_c%0d", lat, c), m_rv0, c >= 1 + lat && c <= 5 + lat);
            check($sformatf("s%0d_busy_c%0d", lat, c), m_busy, c >= 1 && c <= 5 + lat);
            if (c >= 1 && c <= 5)
                check($sformatf("s%0d_addr_c%0d", lat, c), m_addr, c - 1);
            if (c >= 1 + lat && c <= 5 + lat)
                check($sformatf("s%0d_rdata_c%0d", lat, c), m_rdata, exp_data[c-1-lat]);
            if (m_ack0) addr++;
        end
        drive(1'b0, '0, 1'b0, '0);
        sel2 = 1'b0;
    endtask

    initial begin
        int acks0, acks1;

        // Reset state
        do_reset();
        settle();
        check("rst_gnt0", b1.gnt0, 0);
        check("rst_gnt1", b1.gnt1, 0);
        check("rst_rv0", b1.rvalid0, 0);
        check("rst_rv1", b1.rvalid1, 0);
        check("rst_busy", busy1, 0);
        check("rst_en", bram_en1, 0);
        check("rst_addr", bram_addr1, 0);

        // Single-port stream, RD_LAT=1
        run_stream(1);

        // Both ports continuous: 16-access bursts alternate, port 0 first
        do_reset();
        for (int c = 0; c <= 48; c++) begin
            if (c > 0) tick();
            drive(1'b1, 13'd7, 1'b1, 13'd9);
            settle();
            check($sformatf("rr_ack0_c%0d", c), b1.ack0, (c >= 1 && c <= 16) || (c >= 33 && c <= 48));
            check($sformatf("rr_ack1_c%0d", c), b1.ack1, c >= 17 && c <= 32);
            check($sformatf("rr_gnt1_c%0d", c), b1.gnt1, c >= 17 && c <= 32);
            check($sformatf("rr_excl_c%0d", c), b1.ack0 & b1.ack1, 0);
        end

        // Port 1 alone for 40 reads: ownership kept across counter wrap
        do_reset();
        acks1 = 0;
        for (int c = 0; c <= 42; c++) begin
            if (c > 0) tick();
            drive(1'b0, '0, c <= 40, AW'(acks1));
            settle();
            check($sformatf("solo_ack1_c%0d", c), b1.ack1, c >= 1 && c <= 40);
            check($sformatf("solo_gnt1_c%0d", c), b1.gnt1, c >= 1 && c <= 41);
            if (b1.ack1) acks1++;
        end
        check("solo_ack_count", acks1, 40);

        // Port 0 drops after 3 reads while port 1 waits: handover, data routing
        do_reset();
        acks0 = 0;
        acks1 = 0;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) tick();
            drive(acks0 < 3, AW'(acks0), acks1 < 1, 13'd4);
            settle();
            check($sformatf("ho_ack0_c%0d", c), b1.ack0, c >= 1 && c <= 3);
            check($sformatf("ho_ack1_c%0d", c), b1.ack1, c == 5);
            check($sformatf("ho_gnt1_c%0d", c), b1.gnt1, c >= 5 && c <= 6);
            check($sformatf("ho_rv0_c%0d", c), b1.rvalid0, c >= 2 && c <= 4);
            check($sformatf("ho_rv1_c%0d", c), b1.rvalid1, c == 6);
            if (c >= 2 && c <= 4)
                check($sformatf("ho_rdata0_c%0d", c), b1.rdata, exp_data[c-2]);
            if (c == 6)
                check("ho_rdata1", b1.rdata, 8'h5E);
            if (b1.ack0) acks0++;
            if (b1.ack1) acks1++;
        end

        // Reset with a read in flight, then recovery favours port 0
        do_reset();
        drive(1'b1, 13'd3, 1'b0, '0);
        tick();
        drive(1'b1, 13'd3, 1'b0, '0);
        settle();
        check("mr_ack0", b1.ack0, 1);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        reset_n = 1'b0;
        settle();
        check("mr_rv0", b1.rvalid0, 0);
        check("mr_rv1", b1.rvalid1, 0);
        check("mr_gnt0", b1.gnt0, 0);
        check("mr_gnt1", b1.gnt1, 0);
        check("mr_busy", busy1, 0);
        tick();
        reset_n = 1'b1;
        drive(1'b1, 13'd1, 1'b1, 13'd2);
        settle();
        check("mr_idle_gnt0", b1.gnt0, 0);
        tick();
        check("mr_rec_gnt0", b1.gnt0, 1);
        check("mr_rec_gnt1", b1.gnt1, 0);
        check("mr_rec_ack0", b1.ack0, 1);
        check("mr_rec_ack1", b1.ack1, 0);
        drive(1'b0, '0, 1'b0, '0);

        // Single-port stream, RD_LAT=2
        run_stream(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

endmodule
